// File: rtl/buzzer_pkg.sv
// Buzzer player shared types and song word layout.
// Imported by the player FSM and its prescaler.
package buzzer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PLAY,
    ADV,
    DONE
  } state_t;

  localparam int TONE_MSB = 11;
  localparam int TONE_LSB = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;

  localparam logic [11:0] END_WORD = 12'h000;

endpackage

// File: rtl/tick_gen.sv
// Tick prescaler: one-cycle strobe every TICK_DIV clocks.
// Held at zero while clr is high.
module tick_gen #(
  parameter int TICK_DIV = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/buzzer_player.sv
// Piezo song player: fetches song words, plays each as a
// square-wave tone for its duration, stops on END_WORD.
module buzzer_player
  import buzzer_pkg::*;
#(
  parameter int TICK_DIV   = 500,
  parameter int BEAT_TICKS = 12500,
  parameter int ROM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play,
  input  logic        stop,
  input  logic [11:0] note_data,
  output logic        note_adv,
  output logic        buzzer,
  output logic        busy,
  output logic        done,
  output logic [7:0]  cur_note
);

  localparam int DW = $clog2(16 * BEAT_TICKS + 1);
  localparam int WW = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;

  state_t          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [7:0]      tone_q, tone_d;
  logic [3:0]      dcode_q, dcode_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [7:0]      hp_q, hp_d;
  logic            buzz_q, buzz_d;

  logic            tick;
  logic [4:0]      units;
  logic [DW-1:0]   dur_lim;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q != PLAY),
    .tick (tick)
  );

  // Duration code 0 stands for 16 units.
  assign units   = (dcode_q == 4'd0) ? 5'd16 : {1'b0, dcode_q};
  assign dur_lim = DW'(units) * DW'(BEAT_TICKS);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tone_d  = tone_q;
    dcode_d = dcode_q;
    dcnt_d  = dcnt_q;
    hp_d    = hp_q;
    buzz_d  = buzz_q;
    unique case (state_q)
      IDLE: begin
        buzz_d = 1'b0;
        if (play) begin
          state_d = LOAD;
          wait_d  = '0;
        end
      end
      LOAD: begin
        if (wait_q == WW'(ROM_LAT)) begin
          if (note_data == END_WORD) begin
            state_d = DONE;
          end else begin
            state_d = PLAY;
            tone_d  = note_data[TONE_MSB:TONE_LSB];
            dcode_d = note_data[DUR_MSB:DUR_LSB];
            dcnt_d  = '0;
            hp_d    = '0;
            buzz_d  = 1'b0;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      PLAY: begin
        if (tone_q == 8'd0) buzz_d = 1'b0;
        if (tick) begin
          if (tone_q != 8'd0) begin
            if (hp_q == tone_q - 8'd1) begin
              hp_d   = '0;
              buzz_d = ~buzz_q;
            end else begin
              hp_d = hp_q + 8'd1;
            end
          end
          if (dcnt_q == dur_lim - 1'b1) begin
            state_d = ADV;
            buzz_d  = 1'b0;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      ADV: begin
        state_d = LOAD;
        wait_d  = '0;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      buzz_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      tone_q  <= '0;
      dcode_q <= '0;
      dcnt_q  <= '0;
      hp_q    <= '0;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tone_q  <= tone_d;
      dcode_q <= dcode_d;
      dcnt_q  <= dcnt_d;
      hp_q    <= hp_d;
      buzz_q  <= buzz_d;
    end
  end

  assign note_adv = (state_q == ADV);
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign buzzer   = buzz_q;
  assign cur_note = (state_q == PLAY) ? tone_q : 8'd0;

endmodule

// File: tb/tb_buzzer_player.sv
// Directed bench for buzzer_player with a latency-accurate ROM.
// Small parameters keep note lengths to a few hundred clocks.
module tb_buzzer_player;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic [11:0] note_data;
  logic        note_adv, buzzer, busy, done;
  logic [7:0]  cur_note;

  always #5 clk = ~clk;

  buzzer_player #(
    .TICK_DIV  (4),
    .BEAT_TICKS(2),
    .ROM_LAT   (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .play     (play),
    .stop     (stop),
    .note_data(note_data),
    .note_adv (note_adv),
    .buzzer   (buzzer),
    .busy     (busy),
    .done     (done),
    .cur_note (cur_note)
  );

  // ROM: address steps on note_adv, data two cycles behind.
  logic [11:0] rom [4];
  logic [1:0]  addr;
  logic        rom_rst = 1'b0;
  logic [11:0] p1, p2;

  always @(posedge clk) begin
    if (rom_rst)       addr <= 2'd0;
    else if (note_adv) addr <= addr + 2'd1;
    p1 <= rom[addr];
    p2 <= p1;
  end
  assign note_data = p2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int n_busy, n_adv, n_done, at_adv, at_done;
  int n_note, n_hi, n_rise, note_max;

  task automatic start(input logic [11:0] w0, input logic [11:0] w1);
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = 12'h000;
    rom[3] = 12'h000;
    @(negedge clk);
    rom_rst = 1'b1;
    @(negedge clk);
    rom_rst = 1'b0;
    play = 1'b1;
  endtask

  task automatic observe(input int n, input int replay_at);
    logic prev;
    prev = 1'b0;
    n_busy = 0; n_adv = 0; n_done = 0;
    at_adv = -1; at_done = -1;
    n_note = 0; n_hi = 0; n_rise = 0; note_max = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (note_adv) begin
        n_adv++;
        if (at_adv < 0) at_adv = i;
      end
      if (done) begin
        n_done++;
        if (at_done < 0) at_done = i;
      end
      if (cur_note != 8'd0) n_note++;
      if (int'(cur_note) > note_max) note_max = int'(cur_note);
      if (buzzer) n_hi++;
      if (buzzer && !prev) n_rise++;
      prev = buzzer;
      play = (i == replay_at);
    end
    play = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_buzz", buzzer, 0);
    chk("rst_adv", note_adv, 0);
    chk("rst_done", done, 0);
    chk("rst_note", cur_note, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    start(12'h031, 12'h000);
    observe(40, -1);
    chk("a_busy", n_busy, 16);
    chk("a_note", n_note, 8);
    chk("a_tone", note_max, 3);
    chk("a_hi", n_hi, 0);
    chk("a_nadv", n_adv, 1);
    chk("a_atadv", at_adv, 11);
    chk("a_ndone", n_done, 1);
    chk("a_atdone", at_done, 15);

    start(12'h010, 12'h000);
    observe(160, -1);
    chk("b_busy", n_busy, 136);
    chk("b_note", n_note, 128);
    chk("b_tone", note_max, 1);
    chk("b_hi", n_hi, 64);
    chk("b_rise", n_rise, 16);
    chk("b_atadv", at_adv, 131);
    chk("b_atdone", at_done, 135);

    start(12'h002, 12'h000);
    observe(40, -1);
    chk("r_busy", n_busy, 24);
    chk("r_note", n_note, 0);
    chk("r_hi", n_hi, 0);
    chk("r_atadv", at_adv, 19);
    chk("r_ndone", n_done, 1);

    start(12'h031, 12'h000);
    observe(40, 5);
    chk("p_busy", n_busy, 16);
    chk("p_nadv", n_adv, 1);
    chk("p_ndone", n_done, 1);

    start(12'h010, 12'h000);
    observe(18, -1);
    chk("s_pre", buzzer, 1);
    stop = 1'b1;
    @(negedge clk);
    chk("s_busy", busy, 0);
    chk("s_buzz", buzzer, 0);
    chk("s_done", done, 0);
    chk("s_note", cur_note, 0);
    stop = 1'b0;
    observe(150, -1);
    chk("s_nbusy", n_busy, 0);
    chk("s_nadv", n_adv, 0);
    chk("s_ndone", n_done, 0);

    start(12'h010, 12'h000);
    observe(18, -1);
    chk("x_pre", buzzer, 1);
    rst_n = 1'b0;
    #1;
    chk("x_busy", busy, 0);
    chk("x_buzz", buzzer, 0);
    chk("x_note", cur_note, 0);
    chk("x_adv", note_adv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    observe(30, -1);
    chk("x_nbusy", n_busy, 0);
    chk("x_nadv", n_adv, 0);
    chk("x_ndone", n_done, 0);

    play = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    chk("ps_busy", busy, 0);
    play = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    chk("ps_busy2", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/buzzer_player.md
BUZZER_PLAYER -- requirements
Module: buzzer_player

Interface
REQ-001 Parameter TICK_DIV, default 500: clk cycles per time tick (10 us at 50 MHz).
REQ-002 Parameter BEAT_TICKS, default 12500: ticks per duration unit (125 ms).
REQ-003 Parameter ROM_LAT, default 2: cycles from note_adv pulse to valid note_data.
REQ-004 clk  input  1  sole clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 play  input  1  start pulse; honoured only in IDLE.
REQ-007 stop  input  1  abort, level; returns block to IDLE.
REQ-008 note_data  input  12  song word from address-counter/ROM side.
REQ-009 note_adv  output  1  one-cycle request to advance song address.
REQ-010 buzzer  output  1  square-wave drive to piezo.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on end-of-song.
REQ-013 cur_note  output  8  tone code of note now playing; 0 when idle or resting.

Function
REQ-014 Word format: [11:4] tone code = buzzer half-period in ticks (0 = rest); [3:0] duration in units (0 means 16); word 12'h000 = end of song.
REQ-015 FSM states: IDLE, LOAD, PLAY, ADV, DONE.
REQ-016 IDLE: play=1 -> LOAD; outputs buzzer=0, note_adv=0, cur_note=0.
REQ-017 LOAD: wait counter runs ROM_LAT cycles, then note_data is latched on the following edge.
REQ-018 Latched word 12'h000 -> DONE; otherwise -> PLAY, tick prescaler and duration counters cleared on the same edge.
REQ-019 PLAY: tick = one-cycle strobe every TICK_DIV cycles; half-period counter toggles buzzer every tone-code ticks; tone 0 holds buzzer=0.
REQ-020 PLAY: duration = code*BEAT_TICKS ticks (16*BEAT_TICKS for code 0); on last tick -> ADV, buzzer forced 0.
REQ-021 ADV: note_adv=1 for exactly one cycle, then -> LOAD.
REQ-022 DONE: done=1 for exactly one cycle, then -> IDLE; no note_adv issued.
REQ-023 stop=1 in any state: next state IDLE, buzzer=0 next cycle, no done pulse; stop has priority over play and all transitions.
REQ-024 play while busy ignored; play and stop same cycle in IDLE -> remain IDLE.
REQ-025 Counter widths sized by $clog2 of parameters; duration counter holds 16*BEAT_TICKS without wrap.
REQ-026 note_data sampled only on the latch edge; changes at other times have no effect.

Reset
REQ-027 rst_n=0 asynchronously forces IDLE, all counters 0, buzzer=0, note_adv=0, done=0, busy=0, cur_note=0.
REQ-028 Reset mid-note abandons the note; no note_adv or done pulse emitted on release.

Structure
REQ-029 Shared package buzzer_pkg holds state enum, field positions TONE_MSB/LSB, DUR_MSB/LSB, END_WORD=12'h000.
REQ-030 Sub-module tick_gen (parameter TICK_DIV; inputs clk, rst_n, clr; output tick) provides the prescaler.

Verification (TICK_DIV=4, BEAT_TICKS=2, ROM_LAT=2, ROM model honouring ROM_LAT)
REQ-031 Song {12'h031, 12'h000}, play pulse -> buzzer toggles every 12 cycles (tone 3) for 8 cycles total... bench checks 2*4=8 cycles of PLAY, one note_adv, then done pulse, busy falls.
REQ-032 Word 12'h010 (tone 1, dur 0) -> PLAY lasts 16*2*4=128 cycles, buzzer period 8 cycles.
REQ-033 Word 12'h002 (rest, dur 2) -> buzzer held 0, cur_note=0, PLAY 16 cycles, then note_adv.
REQ-034 stop asserted mid-PLAY -> buzzer=0 and IDLE next cycle, busy=0, no done, no further note_adv.
REQ-035 rst_n low mid-PLAY -> all outputs 0 immediately; after release block idles until play.
REQ-036 play asserted during PLAY and simultaneously with stop in IDLE -> no state change from play in either case.
